// File: rtl/fpu_add_sub_pkg.sv
// Shared constants and types for the FPU add/sub operand-alignment stage.
package fpu_add_sub_pkg;

  localparam int SIZE_EXP = 8;
  localparam int SIZE_MAN = 23;
  localparam int SIZE_GRS = 3;
  localparam int SIZE_SIG = SIZE_MAN + 1;
  localparam int SIZE_ALN = SIZE_SIG + SIZE_GRS;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic                sign;
    logic [SIZE_EXP-1:0] exp;
    logic [SIZE_MAN-1:0] man;
  } fp32_t;

  typedef struct packed {
    logic                sign_large;
    logic [SIZE_EXP-1:0] exp_large;
    logic [SIZE_SIG-1:0] sig_large;
    logic [SIZE_SIG-1:0] sig_small;
    logic [SIZE_EXP-1:0] diff;
    logic                eff_sub;
    logic                swap;
  } align_s1_t;

  // Denormals have no hidden bit but share the exponent of the smallest normal.
  function automatic logic [SIZE_SIG-1:0] sig_of(input fp32_t f);
    return {|f.exp, f.man};
  endfunction

  function automatic logic [SIZE_EXP-1:0] eff_exp_of(input fp32_t f);
    return (f.exp == '0) ? SIZE_EXP'(1) : f.exp;
  endfunction

endpackage

// File: rtl/add_sub_align_shift.sv
// Combinational right barrel shifter: bits shifted out collapse into the sticky LSB,
// and shift amounts beyond the datapath width saturate to a lone sticky bit.
module add_sub_align_shift
  import fpu_add_sub_pkg::*;
(
  input  logic [SIZE_ALN-1:0] sig_in,
  input  logic [SIZE_EXP-1:0] shamt,
  output logic [SIZE_ALN-1:0] sig_out
);

  logic [SIZE_ALN-1:0] shifted;
  logic [SIZE_ALN-1:0] lost_mask;

  always_comb begin
    shifted   = sig_in >> shamt;
    lost_mask = ~({SIZE_ALN{1'b1}} << shamt);
    if (shamt >= SIZE_EXP'(SIZE_ALN)) begin
      sig_out = {{(SIZE_ALN-1){1'b0}}, |sig_in};
    end else begin
      sig_out = {shifted[SIZE_ALN-1:1], shifted[0] | (|(sig_in & lost_mask))};
    end
  end

endmodule

// File: rtl/fpu_add_sub_align.sv
// Two-stage valid/ready operand alignment for the FPU adder: compare/swap, then align.
// Optional NaN/Inf detection is built when FPU_ALIGN_SPECIAL_EN is defined.
module fpu_add_sub_align
  import fpu_add_sub_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_data_a,
  input  logic [31:0]         i_data_b,
  input  logic                i_op,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sign_large,
  output logic [SIZE_EXP-1:0] o_exp_large,
  output logic [SIZE_ALN-1:0] o_man_large,
  output logic [SIZE_ALN-1:0] o_man_small,
  output logic                o_eff_sub,
  output logic                o_swap,
  output logic                o_special,
  output logic [31:0]         o_special_res
);

  fp32_t               op_a;
  fp32_t               op_b;
  logic                sign_b_eff;
  logic [SIZE_EXP-1:0] exp_a;
  logic [SIZE_EXP-1:0] exp_b;
  logic [SIZE_SIG-1:0] sig_a;
  logic [SIZE_SIG-1:0] sig_b;
  logic [SIZE_EXP:0]   diff_sum;
  logic                swap;
  logic [SIZE_EXP-1:0] diff_abs;
  align_s1_t           s1_next;
  align_s1_t           s1;
  logic                s1_valid;
  logic                s2_valid;
  logic                s1_load;
  logic                s2_load;
  logic [SIZE_ALN-1:0] small_aligned;

  assign op_a       = i_data_a;
  assign op_b       = i_data_b;
  assign sign_b_eff = op_b.sign ^ i_op;
  assign exp_a      = eff_exp_of(op_a);
  assign exp_b      = eff_exp_of(op_b);
  assign sig_a      = sig_of(op_a);
  assign sig_b      = sig_of(op_b);

  // Carry out of A + ~B + 1 is set exactly when exp_a >= exp_b.
  assign diff_sum = {1'b0, exp_a} + {1'b0, ~exp_b} + {{SIZE_EXP{1'b0}}, 1'b1};
  assign swap     = !diff_sum[SIZE_EXP] || ((exp_a == exp_b) && (sig_b > sig_a));
  assign diff_abs = diff_sum[SIZE_EXP] ? diff_sum[SIZE_EXP-1:0]
                                       : (~diff_sum[SIZE_EXP-1:0] + SIZE_EXP'(1));

  assign s1_next.sign_large = swap ? sign_b_eff : op_a.sign;
  assign s1_next.exp_large  = swap ? exp_b : exp_a;
  assign s1_next.sig_large  = swap ? sig_b : sig_a;
  assign s1_next.sig_small  = swap ? sig_a : sig_b;
  assign s1_next.diff       = diff_abs;
  assign s1_next.eff_sub    = op_a.sign ^ sign_b_eff;
  assign s1_next.swap       = swap;

  assign s2_load = !s2_valid || i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign o_ready = s1_load;
  assign o_valid = s2_valid;

  add_sub_align_shift u_shift (
    .sig_in  ({s1.sig_small, {SIZE_GRS{1'b0}}}),
    .shamt   (s1.diff),
    .sig_out (small_aligned)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
      if (i_valid) s1 <= s1_next;
    end
  end

  // Held outputs stay bit-stable because data only moves on a stage-2 load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid     <= 1'b0;
      o_sign_large <= 1'b0;
      o_exp_large  <= '0;
      o_man_large  <= '0;
      o_man_small  <= '0;
      o_eff_sub    <= 1'b0;
      o_swap       <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_sign_large <= s1.sign_large;
        o_exp_large  <= s1.exp_large;
        o_man_large  <= {s1.sig_large, {SIZE_GRS{1'b0}}};
        o_man_small  <= small_aligned;
        o_eff_sub    <= s1.eff_sub;
        o_swap       <= s1.swap;
      end
    end
  end

`ifdef FPU_ALIGN_SPECIAL_EN
  logic        a_max;
  logic        b_max;
  logic        any_nan;
  logic        special_in;
  logic [31:0] special_res_in;
  logic        s1_special;
  logic [31:0] s1_special_res;

  assign a_max      = &op_a.exp;
  assign b_max      = &op_b.exp;
  assign any_nan    = (a_max && |op_a.man) || (b_max && |op_b.man);
  assign special_in = a_max || b_max;

  // Inf minus Inf of the same magnitude has no meaningful sign, so it becomes NaN.
  always_comb begin
    special_res_in = '0;
    if (any_nan || (a_max && b_max && s1_next.eff_sub)) special_res_in = QNAN;
    else if (a_max) special_res_in = {op_a.sign, {SIZE_EXP{1'b1}}, {SIZE_MAN{1'b0}}};
    else if (b_max) special_res_in = {sign_b_eff, {SIZE_EXP{1'b1}}, {SIZE_MAN{1'b0}}};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_special     <= 1'b0;
      s1_special_res <= '0;
      o_special      <= 1'b0;
      o_special_res  <= '0;
    end else begin
      if (s1_load && i_valid) begin
        s1_special     <= special_in;
        s1_special_res <= special_res_in;
      end
      if (s2_load && s1_valid) begin
        o_special     <= s1_special;
        o_special_res <= s1_special_res;
      end
    end
  end
`else
  assign o_special     = 1'b0;
  assign o_special_res = '0;
`endif

endmodule
